// File: rtl/fll_pkg.sv
// Shared definitions for the FLL lock controller: state encoding,
// thermometer encoder and the signed error width helper.
package fll_pkg;

  typedef logic [1:0] fll_state_t;

  localparam fll_state_t ST_SYNC = 2'd0;
  localparam fll_state_t ST_ACQ  = 2'd1;
  localparam fll_state_t ST_LOCK = 2'd2;

  // Thermometer code: bit i set iff i < n. Callers truncate to their trim width.
  function automatic logic [63:0] therm(input logic [7:0] n);
    logic [63:0] t;
    t = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < int'(n)) t[i] = 1'b1;
    end
    return t;
  endfunction

  // One extra bit so P - div never overflows when both are treated as unsigned.
  function automatic int err_width(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage

// File: rtl/fll_osc_sync.sv
// Brings the asynchronous reference oscillator into the DCO clock domain
// and produces a single-cycle pulse on each synchronised rising edge.
module fll_osc_sync (
  input  logic clock,
  input  logic reset,
  input  logic osc,
  output logic e
);

  logic s1, s2, s3;

  // Two-flop synchroniser followed by the edge-history flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= osc;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign e = s2 & ~s3;

endmodule

// File: rtl/fll_lock_controller.sv
// DCO trim loop: counts DCO cycles per reference period, steps a
// thermometer trim code toward the target and reports frequency lock.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   SYNC    | waiting for the first reference edge; that period is partial
//   ACQ     | evaluating periods, counting consecutive in-window periods
//   LOCK    | locked; counting consecutive misses for hysteresis
module fll_lock_controller
  import fll_pkg::*;
#(
  parameter int TRIM_W    = 26,
  parameter int DIV_W     = 8,
  parameter int CNT_W     = DIV_W + 1,
  parameter int INIT_CODE = TRIM_W / 2,
  parameter int TOL       = 1,
  parameter int COARSE    = 4,
  parameter int LOCK_N    = 8,
  parameter int UNLOCK_N  = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         osc,
  input  logic [DIV_W-1:0]             div,
  input  logic                         dco,
  input  logic [TRIM_W-1:0]            ext_trim,
  output logic [TRIM_W-1:0]            trim,
  output logic [$clog2(TRIM_W+1)-1:0]  code,
  output logic                         locked,
  output logic [CNT_W-1:0]             period,
  output logic                         upd
);

  localparam int CODE_W = $clog2(TRIM_W + 1);
  localparam int ERR_W  = err_width(CNT_W);
  localparam int RUN_W  = $clog2(LOCK_N + 1);
  localparam int MISS_W = $clog2(UNLOCK_N + 1);

  localparam logic [CNT_W-1:0]         CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CODE_W-1:0]        CODE_MAX  = CODE_W'(TRIM_W);
  localparam logic [CODE_W-1:0]        CODE_INIT = CODE_W'(INIT_CODE);
  localparam logic signed [ERR_W-1:0]  TOL_S     = ERR_W'(TOL);
  localparam logic [ERR_W-1:0]         COARSE_U  = ERR_W'(COARSE);
  localparam logic [RUN_W-1:0]         RUN_MAX   = RUN_W'(LOCK_N);
  localparam logic [MISS_W-1:0]        MISS_MAX  = MISS_W'(UNLOCK_N);

  logic                     e;
  logic [CNT_W-1:0]         cnt;
  fll_state_t               state, state_d;
  logic [RUN_W-1:0]         run_cnt, run_d, run_inc;
  logic [MISS_W-1:0]        miss_cnt, miss_d, miss_inc;
  logic                     locked_d;
  logic [CNT_W-1:0]         p_meas;
  logic signed [ERR_W-1:0]  err;
  logic [ERR_W-1:0]         err_abs;
  logic                     too_slow, too_fast, in_win, eval;
  logic [CODE_W-1:0]        step, code_up, code_dn, code_d;
  logic [CODE_W:0]          up_sum;

  fll_osc_sync u_sync (
    .clock (clock),
    .reset (reset),
    .osc   (osc),
    .e     (e)
  );

  // Period measurement and error classification against the target.
  always_comb begin
    p_meas   = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
    err      = $signed({1'b0, p_meas}) - $signed({{(ERR_W-DIV_W){1'b0}}, div});
    err_abs  = err[ERR_W-1] ? ERR_W'(-err) : ERR_W'(err);
    // A saturated count means the reference is far slower than the DCO can count:
    // treat it as too slow regardless of the arithmetic sign.
    too_slow = (p_meas == CNT_MAX) || (err < -TOL_S);
    too_fast = !too_slow && (err > TOL_S);
    in_win   = !too_slow && !too_fast;
    step     = (err_abs > COARSE_U) ? CODE_W'(2) : CODE_W'(1);
    eval     = e && (state != ST_SYNC);
  end

  // Saturating code stepping.
  always_comb begin
    up_sum  = {1'b0, code} + {1'b0, step};
    code_up = (up_sum > {1'b0, CODE_MAX}) ? CODE_MAX : up_sum[CODE_W-1:0];
    code_dn = (code < step) ? '0 : code - step;
    code_d  = code;
    if (eval) begin
      if (too_fast)      code_d = code_up;
      else if (too_slow) code_d = code_dn;
    end
  end

  // Lock FSM with run/miss hysteresis counters.
  always_comb begin
    state_d  = state;
    run_d    = run_cnt;
    miss_d   = miss_cnt;
    locked_d = locked;
    run_inc  = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
    miss_inc = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + MISS_W'(1);
    if (e) begin
      case (state)
        ST_SYNC: state_d = ST_ACQ;
        ST_ACQ, ST_LOCK: begin
          if (in_win) begin
            run_d  = run_inc;
            miss_d = '0;
            if (state == ST_ACQ && run_inc >= RUN_MAX) begin
              state_d  = ST_LOCK;
              locked_d = 1'b1;
            end
          end else if (state == ST_LOCK) begin
            if (miss_inc >= MISS_MAX) begin
              state_d  = ST_ACQ;
              locked_d = 1'b0;
              run_d    = '0;
              miss_d   = '0;
            end else begin
              miss_d = miss_inc;
            end
          end else begin
            run_d  = '0;
            miss_d = '0;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  // State, counters and registered outputs; bypass freezes the loop but keeps the code.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      state    <= ST_SYNC;
      run_cnt  <= '0;
      miss_cnt <= '0;
      code     <= CODE_INIT;
      trim     <= TRIM_W'(therm(8'(INIT_CODE)));
      locked   <= 1'b0;
      period   <= '0;
      upd      <= 1'b0;
    end else if (dco) begin
      cnt      <= '0;
      state    <= ST_SYNC;
      run_cnt  <= '0;
      miss_cnt <= '0;
      trim     <= ext_trim;
      locked   <= 1'b0;
      upd      <= 1'b0;
    end else begin
      cnt      <= e ? '0 : p_meas;
      state    <= state_d;
      run_cnt  <= run_d;
      miss_cnt <= miss_d;
      code     <= code_d;
      trim     <= TRIM_W'(therm(8'(code_d)));
      locked   <= locked_d;
      upd      <= eval;
      if (eval) period <= p_meas;
    end
  end

endmodule

// File: tb/tb_fll_lock_controller.sv
// Directed bench for fll_lock_controller with a scoreboard: every reference
// edge that should be evaluated pushes its expected outcome; a monitor pops on upd.
module tb_fll_lock_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        osc;
  logic [7:0]  div;
  logic        dco;
  logic [25:0] ext_trim;
  logic [25:0] trim;
  logic [4:0]  code;
  logic        locked;
  logic [8:0]  period;
  logic        upd;

  fll_lock_controller dut (
    .clock    (clock),
    .reset    (reset),
    .osc      (osc),
    .div      (div),
    .dco      (dco),
    .ext_trim (ext_trim),
    .trim     (trim),
    .code     (code),
    .locked   (locked),
    .period   (period),
    .upd      (upd)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int code;
    int locked;
    int period;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   upd_seen = 0;

  int m_code, m_locked, m_run, m_miss, m_sync, div_v, last_rise;

  function automatic logic [25:0] therm_tb(input int n);
    logic [25:0] t;
    t = '0;
    for (int i = 0; i < 26; i++) if (i < n) t[i] = 1'b1;
    return t;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h) t=%0t", name, act, act, req, req, $time);
    end
  endtask

  // Reference model of one evaluated reference edge.
  task automatic model_edge(input int gap);
    int p, err, step, win;
    p = (gap > 511) ? 511 : gap;
    if (m_sync != 0) begin
      m_sync = 0;
      return;
    end
    err  = p - div_v;
    step = (err > 4 || err < -4) ? 2 : 1;
    win  = 0;
    if (p == 511 || err < -1)  m_code = (m_code < step) ? 0 : m_code - step;
    else if (err > 1)          m_code = (m_code + step > 26) ? 26 : m_code + step;
    else                       win = 1;
    if (win != 0) begin
      m_run  = (m_run < 8) ? m_run + 1 : 8;
      m_miss = 0;
      if (m_locked == 0 && m_run == 8) m_locked = 1;
    end else if (m_locked != 0) begin
      m_miss++;
      if (m_miss >= 2) begin
        m_locked = 0;
        m_run    = 0;
        m_miss   = 0;
      end
    end else begin
      m_run  = 0;
      m_miss = 0;
    end
    sbq.push_back('{m_code, m_locked, p});
  endtask

  task automatic model_restart();
    m_locked = 0;
    m_run    = 0;
    m_miss   = 0;
    m_sync   = 1;
  endtask

  // Rising osc edge 'gap' cycles after the previous one.
  task automatic send(input int gap);
    int g;
    while (cyc < last_rise + gap) @(negedge clock);
    osc = 1'b1;
    g = cyc - last_rise;
    last_rise = cyc;
    model_edge(g);
    @(negedge clock);
    @(negedge clock);
    osc = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    check(name, sbq.size(), 0);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    repeat (n) @(negedge clock);
    reset = 1'b0;
    sbq.delete();
    m_code = 13;
    model_restart();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_code"},   int'(code),   13);
    check({tag, "_trim"},   int'(trim),   int'(26'h0001FFF));
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_upd"},    int'(upd),    0);
    check({tag, "_period"}, int'(period), 0);
  endtask

  // Monitor: compare every upd against the oldest expectation.
  initial begin
    exp_t ex;
    forever begin
      @(negedge clock);
      if (upd === 1'b1) begin
        upd_seen++;
        if (sbq.size() == 0) begin
          check("unexpected_upd", 1, 0);
        end else begin
          ex = sbq.pop_front();
          check("upd_code",   int'(code),   ex.code);
          check("upd_locked", int'(locked), ex.locked);
          check("upd_period", int'(period), ex.period);
          check("upd_trim",   int'(trim),   int'(therm_tb(ex.code)));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    osc       = 1'b0;
    dco       = 1'b0;
    div       = 8'd20;
    div_v     = 20;
    ext_trim  = '0;
    last_rise = 0;
    m_code    = 13;
    model_restart();

    // Reset and discarded first edge
    pulse_reset(3);
    check_reset_values("reset");
    send(40);
    repeat (8) @(negedge clock);
    check("first_edge_no_upd", upd_seen, 0);

    // Convergence with DCO model P = 30 - code
    for (int i = 0; i < 14; i++) send(30 - m_code);
    drain("drain_conv");
    check("conv_code",   int'(code),   11);
    check("conv_locked", int'(locked), 1);

    // Hysteresis
    send(25);
    drain("drain_hyst1");
    check("hyst_single_locked", int'(locked), 1);
    check("hyst_single_code",   int'(code),   13);
    send(20);
    send(25);
    drain("drain_hyst2");
    check("hyst_one_miss_locked", int'(locked), 1);
    send(25);
    drain("drain_hyst3");
    check("hyst_two_miss_locked", int'(locked), 0);
    check("hyst_two_miss_code",   int'(code),   17);

    // Upper clamp
    for (int i = 0; i < 7; i++) send(30);
    drain("drain_clamp");
    check("clamp_code", int'(code), 26);
    check("clamp_trim", int'(trim), int'(26'h3FFFFFF));

    // DCO bypass
    repeat (10) @(negedge clock);
    dco      = 1'b1;
    ext_trim = 26'h2AAAAAA;
    @(negedge clock);
    check("dco_trim",   int'(trim),   int'(26'h2AAAAAA));
    check("dco_locked", int'(locked), 0);
    check("dco_code",   int'(code),   26);
    repeat (20) @(negedge clock);
    dco = 1'b0;
    model_restart();
    @(negedge clock);
    check("dco_exit_trim", int'(trim), int'(therm_tb(26)));
    check("dco_exit_upd",  int'(upd),  0);
    send(40);
    repeat (8) @(negedge clock);
    check("dco_exit_first_edge", sbq.size(), 0);

    // Saturated counter walks code down to 0
    div   = 8'd255;
    div_v = 255;
    for (int i = 0; i < 15; i++) send(600);
    drain("drain_sat");
    check("sat_code",   int'(code),   0);
    check("sat_period", int'(period), 511);
    check("sat_locked", int'(locked), 0);

    // Reset mid-period
    repeat (100) @(negedge clock);
    pulse_reset(1);
    check_reset_values("midreset");

    // Loop resumes from SYNC after reset
    div   = 8'd20;
    div_v = 20;
    send(50);
    send(17);
    drain("drain_resume");
    check("resume_code", int'(code), 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
